playback_seek_scheduler: RTL and testbench

- Sequences the current-address state machine of the music player.
- Owns play/pause/stop state and generates the sample-rate `count` enable.
- Queues the four seek buttons (+10 s, -10 s, +30 s, -30 s) and issues them one at a time as single-cycle strobes, with a settling gap between strobes.
- Detects end of track from the PCM stream, returns to STOPPED and pulses an address clear.

---
 rtl/playback_seek_scheduler_if.sv | 28 ++
 rtl/playback_seek_scheduler.sv | 157 +++++++++++++++
 tb/tb_playback_seek_scheduler.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/playback_seek_scheduler_if.sv
// Control/status bundle for the playback seek scheduler.
// master = the controller side (buttons, PCM source), slave = the scheduler itself.
interface playback_seek_scheduler_if;
   logic       play_pause;
   logic       stop;
   logic [3:0] seek_req;
   logic [7:0] pcm_value;
   logic       count;
   logic       passa_10s;
   logic       volta_10s;
   logic       passa_30s;
   logic       volta_30s;
   logic       addr_clear;
   logic       track_end;
   logic [1:0] state;

   modport master (
      output play_pause, stop, seek_req, pcm_value,
      input  count, passa_10s, volta_10s, passa_30s, volta_30s,
             addr_clear, track_end, state
   );

   modport slave (
      input  play_pause, stop, seek_req, pcm_value,
      output count, passa_10s, volta_10s, passa_30s, volta_30s,
             addr_clear, track_end, state
   );
endinterface

// File: rtl/playback_seek_scheduler.sv
// Playback seek scheduler: play/pause/stop FSM, sample-rate count enable,
// queued one-at-a-time seek strobes with a settling gap, end-of-track detect.
// Optional macro SEEK_COALESCE_EN: opposing pending seeks (+30/-30, +10/-10)
// cancel each other before anything issues.
module playback_seek_scheduler #(
   parameter int DIV       = 32'd4535,
   parameter int GAP       = 32'd4,
   parameter int END_ZEROS = 32'd64
) (
   input  logic                      clk,
   input  logic                      reset,
   playback_seek_scheduler_if.slave  bus
);
   localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int GW = $clog2(GAP + 1);
   localparam int ZW = $clog2(END_ZEROS + 1);

   localparam logic [1:0] ST_STOPPED = 2'b00;
   localparam logic [1:0] ST_PLAYING = 2'b01;
   localparam logic [1:0] ST_PAUSED  = 2'b10;

   // Fixed issue priority: -30 s (bit2) > +30 s (bit3) > -10 s (bit0) > +10 s (bit1).
   function automatic logic [3:0] pick_seek(input logic [3:0] req);
      logic [3:0] g;
      if (req[2])      g = 4'b0100;
      else if (req[3]) g = 4'b1000;
      else if (req[0]) g = 4'b0001;
      else if (req[1]) g = 4'b0010;
      else             g = 4'b0000;
      return g;
   endfunction

   logic [TW-1:0] tick_q;
   logic [1:0]    state_q, state_d;
   logic [3:0]    pending_q, pending_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [ZW-1:0] zero_q, zero_d;
   logic          count_q, count_d;
   logic [3:0]    strobe_q, strobe_d;
   logic          addr_clear_q, addr_clear_d;
   logic          track_end_q, track_end_d;

   logic          tick_s, eot_s, clr_s, active_s, issue_s;
   logic [3:0]    merged_s, grant_s;

   assign tick_s = (tick_q == TW'(DIV - 1));

   // Free-running sample tick divider.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      tick_q <= '0;
      else if (tick_s) tick_q <= '0;
      else             tick_q <= tick_q + TW'(1);
   end

   // End of track: this tick's zero sample completes the run of END_ZEROS.
   always_comb begin
      eot_s = (state_q == ST_PLAYING) && tick_s && (bus.pcm_value == 8'd0) &&
              (zero_q == ZW'(END_ZEROS - 1));
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_STOPPED;
      else        state_q <= state_d;
   end

   // FSM next state: stop beats end-of-track beats play_pause.
   always_comb begin
      state_d = state_q;
      if (bus.stop || eot_s) begin
         state_d = ST_STOPPED;
      end else if (bus.play_pause) begin
         case (state_q)
            ST_STOPPED: state_d = ST_PLAYING;
            ST_PLAYING: state_d = ST_PAUSED;
            ST_PAUSED:  state_d = ST_PLAYING;
            default:    state_d = ST_STOPPED;
         endcase
      end else if (state_q == 2'b11) begin
         state_d = ST_STOPPED;
      end else begin
         state_d = state_q;
      end
   end

   // Seek queue merge, optional cancellation and single-strobe arbitration.
   always_comb begin
      clr_s    = (bus.stop && (state_q != ST_STOPPED)) || eot_s;
      active_s = ((state_q == ST_PLAYING) || (state_q == ST_PAUSED)) && !bus.stop && !clr_s;
      merged_s = pending_q | bus.seek_req;
`ifdef SEEK_COALESCE_EN
      if (merged_s[3] && merged_s[2]) merged_s[3:2] = 2'b00;
      else                            merged_s[3:2] = merged_s[3:2];
      if (merged_s[1] && merged_s[0]) merged_s[1:0] = 2'b00;
      else                            merged_s[1:0] = merged_s[1:0];
`endif
      issue_s   = active_s && (merged_s != 4'b0000) && (gap_q == '0);
      grant_s   = issue_s ? pick_seek(merged_s) : 4'b0000;
      pending_d = active_s ? (merged_s & ~grant_s) : 4'b0000;
      if (clr_s)             gap_d = '0;
      else if (issue_s)      gap_d = GW'(GAP);
      else if (gap_q != '0)  gap_d = gap_q - GW'(1);
      else                   gap_d = '0;
   end

   // Zero-run counter: only advances on PLAYING ticks, cleared on leaving PLAYING.
   always_comb begin
      zero_d = zero_q;
      if (state_d != ST_PLAYING) begin
         zero_d = '0;
      end else if ((state_q == ST_PLAYING) && tick_s) begin
         if (bus.pcm_value != 8'd0)          zero_d = '0;
         else if (zero_q != ZW'(END_ZEROS))  zero_d = zero_q + ZW'(1);
         else                                zero_d = zero_q;
      end else begin
         zero_d = zero_q;
      end
   end

   // FSM outputs (next values of the registered pulse outputs).
   always_comb begin
      count_d      = tick_s && (state_q == ST_PLAYING);
      strobe_d     = grant_s;
      addr_clear_d = clr_s;
      track_end_d  = eot_s;
   end

   // Queue, gap, zero-run and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending_q    <= 4'b0000;
         gap_q        <= '0;
         zero_q       <= '0;
         count_q      <= 1'b0;
         strobe_q     <= 4'b0000;
         addr_clear_q <= 1'b0;
         track_end_q  <= 1'b0;
      end else begin
         pending_q    <= pending_d;
         gap_q        <= gap_d;
         zero_q       <= zero_d;
         count_q      <= count_d;
         strobe_q     <= strobe_d;
         addr_clear_q <= addr_clear_d;
         track_end_q  <= track_end_d;
      end
   end

   assign bus.count      = count_q;
   assign bus.passa_30s  = strobe_q[3];
   assign bus.volta_30s  = strobe_q[2];
   assign bus.passa_10s  = strobe_q[1];
   assign bus.volta_10s  = strobe_q[0];
   assign bus.addr_clear = addr_clear_q;
   assign bus.track_end  = track_end_q;
   assign bus.state      = state_q;
endmodule

// File: tb/tb_playback_seek_scheduler.sv
// Testbench for playback_seek_scheduler: directed test-plan steps followed by
// a randomized phase, all checked every cycle against a behavioural model.
module tb_playback_seek_scheduler;
   localparam int DIV       = 8;
   localparam int GAP       = 4;
   localparam int END_ZEROS = 6;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   playback_seek_scheduler_if bus();

   playback_seek_scheduler #(.DIV(DIV), .GAP(GAP), .END_ZEROS(END_ZEROS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int tcyc        = 0;
   int strobe_cnt  = 0;

   // behavioural model state
   int   m_state, m_gap, m_zeros, m_cyc;
   bit   m_pend [4];
   int   prio [4] = '{2, 3, 0, 1};
   logic e_count, e_clr, e_end;
   logic [3:0] e_strobe;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic mreset();
      m_state = 0; m_gap = 0; m_zeros = 0; m_cyc = 0;
      for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
   endtask

   function automatic logic [3:0] strobes();
      return {bus.passa_30s, bus.volta_30s, bus.passa_10s, bus.volta_10s};
   endfunction

   // One clock: predict from current inputs, advance, compare all outputs.
   task automatic step();
      bit tick, eot, clr, act;
      int nxt, g;
      bit req [4];
      tick = (m_cyc % DIV) == DIV - 1;
      eot  = (m_state == 1) && tick && (bus.pcm_value == 8'd0) && (m_zeros + 1 >= END_ZEROS);
      if (bus.stop || eot)    nxt = 0;
      else if (bus.play_pause) nxt = (m_state == 1) ? 2 : 1;
      else                     nxt = m_state;
      clr = (bus.stop && m_state != 0) || eot;
      act = (m_state != 0) && !bus.stop && !clr;
      for (int i = 0; i < 4; i++) req[i] = m_pend[i] || bus.seek_req[i];
`ifdef SEEK_COALESCE_EN
      if (req[3] && req[2]) begin req[3] = 1'b0; req[2] = 1'b0; end
      if (req[1] && req[0]) begin req[1] = 1'b0; req[0] = 1'b0; end
`endif
      g = -1;
      if (act && m_gap == 0)
         for (int k = 0; k < 4; k++) if (g < 0 && req[prio[k]]) g = prio[k];
      e_count  = tick && (m_state == 1);
      e_clr    = clr;
      e_end    = eot;
      e_strobe = 4'b0000;
      if (g >= 0) e_strobe[g] = 1'b1;
      for (int i = 0; i < 4; i++) m_pend[i] = act && req[i] && (i != g);
      if (clr)           m_gap = 0;
      else if (g >= 0)   m_gap = GAP;
      else if (m_gap > 0) m_gap--;
      if (nxt != 1) m_zeros = 0;
      else if (m_state == 1 && tick) m_zeros = (bus.pcm_value == 8'd0) ? m_zeros + 1 : 0;
      m_state = nxt;
      m_cyc++;
      @(posedge clk);
      #1;
      tcyc++;
      if (strobes() != 4'b0000) strobe_cnt++;
      chk("state",      {6'd0, bus.state},      m_state[7:0]);
      chk("count",      {7'd0, bus.count},      {7'd0, e_count});
      chk("strobes",    {4'd0, strobes()},      {4'd0, e_strobe});
      chk("addr_clear", {7'd0, bus.addr_clear}, {7'd0, e_clr});
      chk("track_end",  {7'd0, bus.track_end},  {7'd0, e_end});
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic pulse(input logic pp, input logic st, input logic [3:0] sk);
      bus.play_pause = pp; bus.stop = st; bus.seek_req = sk;
      step();
      bus.play_pause = 1'b0; bus.stop = 1'b0; bus.seek_req = 4'b0000;
   endtask

   initial begin
      int t1, t2, s0;
      bit found;
      bus.play_pause = 1'b0; bus.stop = 1'b0; bus.seek_req = 4'b0000; bus.pcm_value = 8'h55;
      mreset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_state",  {6'd0, bus.state}, 8'd0);
      chk("rst_pulses", {1'b0, bus.count, bus.addr_clear, bus.track_end, strobes()}, 8'd0);
      @(negedge clk); reset = 1'b1; mreset();

      // start playing; count every DIV cycles, no strobes
      run(3);
      s0 = strobe_cnt;
      pulse(1'b1, 1'b0, 4'b0000);
      chk("play_state", {6'd0, bus.state}, 8'd1);
      t1 = -1; t2 = -1;
      for (int i = 0; i < 3 * DIV && t2 < 0; i++) begin
         step();
         if (bus.count) begin if (t1 < 0) t1 = tcyc; else t2 = tcyc; end
      end
      chk("count_seen",   {7'd0, (t2 >= 0)}, 8'd1);
      chk("count_period", 8'(t2 - t1), 8'(DIV));
      chk("no_strobes",   8'(strobe_cnt - s0), 8'd0);

      // +30 s and +10 s together: passa_30s next cycle, passa_10s GAP+1 later
      pulse(1'b0, 1'b0, 4'b1010);
      chk("passa30_now", {7'd0, bus.passa_30s}, 8'd1);
      t1 = tcyc; found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin step(); found = bus.passa_10s; end
      chk("passa10_seen", {7'd0, found}, 8'd1);
      chk("passa10_gap",  8'(tcyc - t1), 8'(GAP + 1));

      // opposing +/-10 s
      run(GAP + 2);
      pulse(1'b0, 1'b0, 4'b0011);
`ifdef SEEK_COALESCE_EN
      s0 = strobe_cnt;
      run(20);
      chk("coalesce_none", 8'(strobe_cnt - s0), 8'd0);
`else
      chk("volta10_now", {7'd0, bus.volta_10s}, 8'd1);
      t1 = tcyc; found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin step(); found = bus.passa_10s; end
      chk("opp_passa10_gap", 8'(tcyc - t1), 8'(GAP + 1));
`endif

      // pause, then stop together with -30 s
      run(GAP + 2);
      pulse(1'b1, 1'b0, 4'b0000);
      chk("paused", {6'd0, bus.state}, 8'd2);
      s0 = strobe_cnt;
      pulse(1'b0, 1'b1, 4'b0100);
      chk("stop_clear", {7'd0, bus.addr_clear}, 8'd1);
      chk("stop_state", {6'd0, bus.state}, 8'd0);
      run(12);
      chk("stop_drop", 8'(strobe_cnt - s0), 8'd0);

      // seek while stopped is never latched
      s0 = strobe_cnt;
      pulse(1'b0, 1'b0, 4'b0001);
      run(5);
      pulse(1'b1, 1'b0, 4'b0000);
      run(12);
      chk("stopped_seek", 8'(strobe_cnt - s0), 8'd0);

      // end of track
      bus.pcm_value = 8'd0;
      found = 1'b0;
      for (int i = 0; i < (END_ZEROS + 3) * DIV && !found; i++) begin step(); found = bus.track_end; end
      chk("eot_seen",  {7'd0, found}, 8'd1);
      chk("eot_clear", {7'd0, bus.addr_clear}, 8'd1);
      chk("eot_state", {6'd0, bus.state}, 8'd0);
      t1 = 0;
      for (int i = 0; i < 2 * DIV; i++) begin step(); if (bus.count) t1++; end
      chk("eot_no_count", 8'(t1), 8'd0);
      bus.pcm_value = 8'h33;

      // async reset mid-gap with seeks pending
      pulse(1'b1, 1'b0, 4'b0000);
      pulse(1'b0, 1'b0, 4'b1111);
      step();
      #2 reset = 1'b0;
      #1;
      chk("arst_state",  {6'd0, bus.state}, 8'd0);
      chk("arst_pulses", {1'b0, bus.count, bus.addr_clear, bus.track_end, strobes()}, 8'd0);
      repeat (2) @(posedge clk);
      @(negedge clk); reset = 1'b1; mreset();
      s0 = strobe_cnt;
      run(20);
      chk("arst_no_strobe", 8'(strobe_cnt - s0), 8'd0);

      // randomized phase
      for (int i = 0; i < 3000; i++) begin
         bus.play_pause = ($urandom_range(0, 39) == 0);
         bus.stop       = ($urandom_range(0, 119) == 0);
         bus.seek_req   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
         bus.pcm_value  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
         step();
      end
      bus.play_pause = 1'b0; bus.stop = 1'b0; bus.seek_req = 4'b0000;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
